// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: in-order imem prefetch into a small FIFO, with redirect flush.
// Define IFU_PERF_CNT_EN to build the delivered-instruction counter behind perf_fetch_cnt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] perf_fetch_cnt
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_OS_C = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      pc_mem_q    [FIFO_DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             grant, push, pop;

  // Requests in flight plus buffered words must fit in the FIFO, so a push can never overflow.
  assign occupancy = {1'b0, out_q} + {1'b0, count_q};
  assign imem_req  = reset_n && (state_q == ST_RUN) && !redirect_valid &&
                     (occupancy < {1'b0, DEPTH_C}) && (out_q < MAX_OS_C);
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign push      = imem_rvalid && (state_q == ST_RUN) && !redirect_valid;
  assign id_valid  = (count_q != '0);
  assign pop       = id_valid && id_ready;
  assign id_instr  = id_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign id_pc     = id_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rsp_pc_d  = rsp_pc_q;
    discard_d = discard_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_d     = out_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    if (grant) pc_d = pc_q + 32'd1;
    // Responses come back in order, so the next kept word belongs to rsp_pc_q.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rsp_pc_d = rsp_pc_q + 32'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if ((state_q == ST_FLUSH) && imem_rvalid) discard_d = discard_q - CNT_W'(1);
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      if (state_q == ST_RUN) discard_d = out_d;
      state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
    end else if ((state_q == ST_FLUSH) && (discard_d == '0)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= 32'd0;
    else if (pop) perf_q <= perf_q + 32'd1;
  end

  assign perf_fetch_cnt = perf_q;
`else
  assign perf_fetch_cnt = 32'd0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: word-index PC loaded on reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: prefetch buffer entries, power of two, 2..16.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2: maximum imem requests in flight, 1..FIFO_DEPTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port imem_req  output  1  fetch request valid.
REQ-007 SHALL have port imem_addr  output  32  word index of the requested instruction.
REQ-008 SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid; responses return in request order, latency >=1 cycle after grant.
REQ-010 SHALL have port imem_rdata  input  32  instruction word.
REQ-011 SHALL have port id_valid  output  1  instruction available to decode.
REQ-012 SHALL have port id_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port id_instr  output  32  instruction to decode.
REQ-014 SHALL have port id_pc  output  32  word index of id_instr.
REQ-015 SHALL have port redirect_valid  input  1  PC redirect (branch/jump) request.
REQ-016 SHALL have port redirect_pc  input  32  new word-index PC.
REQ-017 SHALL have port perf_fetch_cnt  output  32  count of instructions delivered to decode.

Function
REQ-018 SHALL hold fetch PC; each granted request (imem_req & imem_gnt) uses imem_addr = PC and increments PC by 1, wrapping 0xFFFFFFFF -> 0.
REQ-019 SHALL assert imem_req only when outstanding + fifo_count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING, in state RUN, with no redirect_valid that cycle.
REQ-020 SHALL keep imem_req and imem_addr stable until granted, except in a redirect cycle, where they may drop.
REQ-021 SHALL write {imem_rdata, its request PC} into FIFO on each non-discarded imem_rvalid; FIFO never overflows, guaranteed by REQ-019.
REQ-022 SHALL present FIFO head on id_valid/id_instr/id_pc; id_valid high iff FIFO non-empty; minimum latency imem_rvalid cycle N -> id_valid cycle N+1.
REQ-023 SHALL pop head on id_valid & id_ready; id_instr/id_pc stable while id_valid & !id_ready.
REQ-024 SHALL allow push and pop in the same cycle with a full FIFO, with count unchanged.
REQ-025 SHALL implement states RUN and FLUSH.
REQ-026 SHALL, on redirect_valid in any state: complete a same-cycle id handshake, then clear FIFO; discard same-cycle imem_rvalid; set PC = redirect_pc; set discard count = outstanding after that cycle's grant/response; go to FLUSH if discard count > 0, else RUN.
REQ-027 SHALL in FLUSH drop each imem_rvalid, decrementing discard count, issue no requests, and return to RUN when count reaches 0.
REQ-028 SHALL, on redirect_valid during FLUSH, reload PC and keep the running discard count.
REQ-029 SHALL increment perf_fetch_cnt per id handshake, wrapping at 2^32.

Reset
REQ-030 SHALL, while reset_n low, force PC = RESET_PC, FIFO empty, outstanding = 0, discard = 0, state RUN, imem_req = 0, id_valid = 0, id_instr = 0, id_pc = 0, perf_fetch_cnt = 0.
REQ-031 SHALL assert imem_req with imem_addr = RESET_PC in the first cycle after reset_n rises; reset mid-transaction abandons all in-flight responses and the environment must not return them.

Configuration
REQ-032 SHALL, with macro IFU_PERF_CNT_EN defined, implement perf_fetch_cnt per REQ-029; without it, perf_fetch_cnt SHALL be constant 0 with no counter flops, and the port SHALL remain.

Verification
REQ-033 SHALL cover: reset, gnt always 1, latency 1, id_ready=1 -> imem_addr 0,1,2,3...; id_pc 0,1,2,3 on consecutive cycles; perf_fetch_cnt=4 after 4 handshakes.
REQ-034 SHALL cover: id_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_req low, no overflow; id_ready=1 -> id_pc 0..3 in order, fetching resumes at 4.
REQ-035 SHALL cover: 2 requests outstanding (latency 3), redirect_pc=0x40 -> both responses dropped, next id_pc=0x40, no imem_req until both responses return.
REQ-036 SHALL cover: redirect in the same cycle as an id handshake and imem_rvalid -> handshake counts, arriving word dropped, FIFO empty next cycle.
REQ-037 SHALL cover: RESET_PC=0xFFFFFFFE -> id_pc 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
REQ-038 SHALL cover: reset_n pulsed low mid-stream -> all outputs at reset values immediately, restart at RESET_PC; with IFU_PERF_CNT_EN undefined, perf_fetch_cnt=0 throughout.
